// File: rtl/video_pkg.sv
// video_pkg -- shared definitions for the video fetch block.
//   MC_*      : bit indices into the one-hot memory-cycle phase vector
//   state_t   : fetch FSM state encoding
//   DEF_AW    : default SRAM word-address width
//   DEF_DEPTH : default FIFO depth in 16-bit words
package video_pkg;

    localparam int MC_VIDEO  = 0;
    localparam int MC_CPU    = 1;
    localparam int MC_DUMMY  = 2;

    localparam int DEF_AW    = 18;
    localparam int DEF_DEPTH = 16;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

endpackage

// File: rtl/video_fetch_vfifo.sv
// vfifo -- synchronous first-word-fall-through FIFO.
// Ports:
//   mclk, rst_n : clock, synchronous active-low reset
//   push, wdata : write request and data (ignored while full)
//   pop         : read request (ignored while empty)
//   flush       : empties the FIFO, overrides push/pop
//   rdata       : head word, valid whenever empty=0
//   level       : occupancy, empty, full : status
module vfifo
    import video_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int W     = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (count == '0);
    assign full  = (count == LW'(DEPTH));
    assign level = count;
    assign rdata = mem[rptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge mclk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PW'(1);
            if (do_pop)
                rptr <= rptr + PW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; contents are only observable
    // through rdata, which is don't-care while the pointers say empty.
    always_ff @(posedge mclk) begin
        if (do_push && !flush)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/video_fetch.sv
// video_fetch -- video-slot SRAM reader with line-burst FSM and FWFT buffer.
// Ports:
//   mclk, rst_n      : 90 MHz controller clock, synchronous active-low reset
//   mc               : one-hot memory-cycle phase (video, cpu, dummy)
//   sram_d           : SRAM read data, captured in the dummy (read-return) slot
//   vaddr            : word address offered to the controller in the video slot
//   start, base_addr, line_words : begin/restart a line burst
//   rd_en, rd_data, empty, level : pixel-side FIFO interface
//   busy, done       : burst in progress / one-cycle end-of-burst pulse
//   underrun         : sticky, set by a pop while empty, cleared by start
// Optional: define VIDEO_FETCH_STATS_EN to add saturating skip_cnt/urun_cnt.
module video_fetch
    import video_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int AW    = DEF_AW,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic [2:0]    mc,
    input  logic [15:0]   sram_d,
    output logic [AW-1:0] vaddr,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    line_words,
    input  logic          rd_en,
    output logic [15:0]   rd_data,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          done,
    output logic          underrun
`ifdef VIDEO_FETCH_STATS_EN
    ,
    output logic [7:0]    skip_cnt,
    output logic [7:0]    urun_cnt
`endif
);

    state_t     state;
    logic [7:0] remaining;
    logic       inflight;
    logic       fifo_full;
    logic       restart;
    logic       slot;
    logic       capture;

    // A zero-length start is a no-op when idle, but still aborts a burst.
    assign restart = start && ((line_words != 8'd0) || (state == FETCH));
    assign slot    = (state == FETCH) && mc[MC_VIDEO] && !restart;
    assign capture = mc[MC_DUMMY] && inflight && !restart;
    assign busy    = (state == FETCH);

    vfifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .mclk  (mclk),
        .rst_n (rst_n),
        .push  (capture),
        .wdata (sram_d),
        .pop   (rd_en),
        .flush (restart),
        .rdata (rd_data),
        .level (level),
        .empty (empty),
        .full  (fifo_full)
    );

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vaddr     <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (restart) begin
                underrun <= 1'b0;
                inflight <= 1'b0;
                if (line_words != 8'd0) begin
                    state     <= FETCH;
                    vaddr     <= base_addr;
                    remaining <= line_words;
                end else begin
                    state <= IDLE;
                end
            end else begin
                if (rd_en && empty)
                    underrun <= 1'b1;
                // Full check ignores a same-cycle pop: one slot of slack.
                if (slot && !fifo_full)
                    inflight <= 1'b1;
                if (capture) begin
                    inflight  <= 1'b0;
                    vaddr     <= vaddr + AW'(1);
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef VIDEO_FETCH_STATS_EN
    always_ff @(posedge mclk) begin
        if (!rst_n || restart) begin
            skip_cnt <= '0;
            urun_cnt <= '0;
        end else begin
            if (slot && fifo_full && skip_cnt != 8'hFF)
                skip_cnt <= skip_cnt + 8'd1;
            if (rd_en && empty && urun_cnt != 8'hFF)
                urun_cnt <= urun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch -- directed self-checking bench for video_fetch.
// The SRAM model returns the low 16 bits of the address latched in the
// video slot, so every captured word identifies the address it came from.
`timescale 1ns/1ps
module tb_video_fetch;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic [2:0]  mc;
    logic [15:0] sram_d;
    logic [17:0] vaddr;
    logic        start;
    logic [17:0] base_addr;
    logic [7:0]  line_words;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        empty;
    logic [4:0]  level;
    logic        busy;
    logic        done;
    logic        underrun;
`ifdef VIDEO_FETCH_STATS_EN
    logic [7:0]  skip_cnt;
    logic [7:0]  urun_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_ref;
    logic [17:0] sram_lat = '0;

    video_fetch dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .mc         (mc),
        .sram_d     (sram_d),
        .vaddr      (vaddr),
        .start      (start),
        .base_addr  (base_addr),
        .line_words (line_words),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .level      (level),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
`ifdef VIDEO_FETCH_STATS_EN
        ,
        .skip_cnt   (skip_cnt),
        .urun_cnt   (urun_cnt)
`endif
    );

    always #5 mclk = ~mclk;

    // Controller phase sequencer: 001 -> 010 -> 100, advanced just after each edge.
    initial begin
        mc = 3'b001;
        forever begin
            @(posedge mclk);
            #1 mc = {mc[1:0], mc[2]};
        end
    end

    // SRAM model: address sampled in the video slot, data returned in the read slot.
    always @(posedge mclk) if (mc[0]) sram_lat <= vaddr;
    assign sram_d = sram_lat[15:0];

    always @(negedge mclk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_burst(input logic [17:0] base, input logic [7:0] words);
        start      = 1'b1;
        base_addr  = base;
        line_words = words;
        @(negedge mclk);
        start = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        @(negedge mclk);
        rd_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge mclk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        logic found;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        line_words = '0;
        rd_en      = 1'b0;
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;

        // Reset state
        check("rst_busy",     busy,     1'b0);
        check("rst_done",     done,     1'b0);
        check("rst_vaddr",    vaddr,    18'h0);
        check("rst_level",    level,    5'd0);
        check("rst_empty",    empty,    1'b1);
        check("rst_underrun", underrun, 1'b0);

        // Basic burst: 4 words from 0x00100
        start_burst(18'h00100, 8'd4);
        check("basic_busy", busy, 1'b1);
        wait_done("basic_done", 60);
        check("basic_busy_fall", busy, 1'b0);
        check("basic_done_phase", mc, 3'b001);
        repeat (5) @(negedge mclk);
        check("basic_done_once", done_cnt, 1);
        check("basic_level", level, 5'd4);
        check("basic_vaddr", vaddr, 18'h00104);
        for (int i = 0; i < 4; i++) pop_check("basic_word", 16'h0100 + 16'(i));
        check("basic_empty", empty, 1'b1);

        // Backpressure: 20 words into a 16-deep FIFO
        done_ref = done_cnt;
        start_burst(18'h00000, 8'd20);
        repeat (100) @(negedge mclk);
        check("bp_level_full", level, 5'd16);
        check("bp_vaddr_hold", vaddr, 18'h00010);
        check("bp_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) pop_check("bp_word", 16'(i));
        wait_done("bp_done", 60);
        check("bp_level_after", level, 5'd16);
        for (int i = 4; i < 20; i++) pop_check("bp_word", 16'(i));
        check("bp_empty", empty, 1'b1);
        check("bp_done_once", done_cnt - done_ref, 1);

        // Address wrap
        start_burst(18'h3FFFE, 8'd3);
        wait_done("wrap_done", 60);
        check("wrap_level", level, 5'd3);
        pop_check("wrap_w0", 16'hFFFE);
        pop_check("wrap_w1", 16'hFFFF);
        pop_check("wrap_w2", 16'h0000);
        check("wrap_vaddr", vaddr, 18'h00001);

        // Underrun
        rd_en = 1'b1;
        @(negedge mclk);
        rd_en = 1'b0;
        check("urun_flag", underrun, 1'b1);
        check("urun_level", level, 5'd0);
        check("urun_empty", empty, 1'b1);
`ifdef VIDEO_FETCH_STATS_EN
        check("urun_cnt1", urun_cnt, 8'd1);
`endif
        start_burst(18'h00040, 8'd1);
        check("urun_clear", underrun, 1'b0);
`ifdef VIDEO_FETCH_STATS_EN
        check("urun_cnt_clear", urun_cnt, 8'd0);
`endif
        wait_done("urun_burst_done", 60);
        pop_check("urun_word", 16'h0040);
`ifdef VIDEO_FETCH_STATS_EN
        rd_en = 1'b1;
        repeat (300) @(negedge mclk);
        rd_en = 1'b0;
        check("urun_cnt_sat", urun_cnt, 8'hFF);
        check("urun_flag2", underrun, 1'b1);
`endif

        // Restart mid-burst with a word in flight
        done_ref = done_cnt;
        start_burst(18'h00000, 8'd8);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (level == 5'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge mclk);
        end
        check("rs_third_capture", found, 1'b1);
        @(negedge mclk);
        check("rs_inflight_phase", mc, 3'b010);
        start_burst(18'h00200, 8'd2);
        check("rs_flushed", level, 5'd0);
        wait_done("rs_done", 60);
        repeat (10) @(negedge mclk);
        check("rs_done_once", done_cnt - done_ref, 1);
        check("rs_level", level, 5'd2);
        pop_check("rs_w0", 16'h0200);
        pop_check("rs_w1", 16'h0201);
        check("rs_empty", empty, 1'b1);

        // Reset mid-burst with a word in flight
        done_ref = done_cnt;
        start_burst(18'h00010, 8'd4);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge mclk);
            if (busy && mc == 3'b010) begin
                found = 1'b1;
                break;
            end
        end
        check("mr_inflight_seen", found, 1'b1);
        rst_n = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
        check("mr_busy",     busy,     1'b0);
        check("mr_vaddr",    vaddr,    18'h0);
        check("mr_level",    level,    5'd0);
        check("mr_empty",    empty,    1'b1);
        check("mr_underrun", underrun, 1'b0);
        repeat (6) @(negedge mclk);
        check("mr_no_push", level, 5'd0);
        check("mr_no_done", done_cnt - done_ref, 0);

        // Zero-length start
        done_ref = done_cnt;
        start_burst(18'h00123, 8'd0);
        check("zl_busy", busy, 1'b0);
        repeat (10) @(negedge mclk);
        check("zl_vaddr", vaddr, 18'h0);
        check("zl_no_done", done_cnt - done_ref, 0);
        check("zl_level", level, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
